instruction_fetch_responder: RTL
================================

Name: instruction_fetch_responder

Overview:
Memory-side responder for the core's instruction-fetch handshake.
- Accepts a word-aligned fetch request (issued by the pipeline during its fetch-request state).
- Returns instruction data after a fixed, parameterised latency, in time for the fetch-receive state.
- Holds the instruction store internally, with a separate load port for boot and testbench preload.
- Flags misaligned, out-of-range and dropped requests.

Parameters:
DATA_WIDTH, 32, instruction word width in bits.
ADDR_WIDTH, 32, byte-address width.
DEPTH, 1024, number of words in the store; need not be a power of two.
READ_LATENCY, 1, cycles from request accept to rsp_valid; legal range is 1 to 15.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  fetch request strobe, one cycle per request.
req_address  in  ADDR_WIDTH  byte address of the instruction.
rsp_valid  out  1  one-cycle pulse; rsp_data and rsp_error are valid.
rsp_data  out  DATA_WIDTH  fetched word; held until the next response.
rsp_error  out  1  response is an error (misaligned or out of range); held with rsp_data.
busy  out  1  a request is in flight and has not yet responded.
req_dropped  out  1  one-cycle pulse: a request arrived while busy and was ignored.
load_en  in  1  write strobe for the store.
load_address  in  ADDR_WIDTH  byte address for the write.
load_data  in  DATA_WIDTH  word to write.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the counter clears.
  - rsp_valid=0, rsp_data=0, rsp_error=0, busy=0, req_dropped=0.
  - Store contents are not reset and are undefined until loaded.
  - A pending request is discarded; no response is issued after reset deasserts.
- States:
  - IDLE: no request in flight.
  - WAIT: request captured, counter running.
- Accepting a request:
  - A request is accepted on an edge where req_valid=1 and state is IDLE.
  - The address is captured and cnt is loaded with READ_LATENCY-1.
  - If cnt would be 0 (READ_LATENCY=1), the response is produced on that same edge and state stays IDLE.
  - Otherwise state moves to WAIT and busy=1.
- WAIT:
  - cnt decrements on each edge.
  - On the edge where cnt==1, the response is produced and state returns to IDLE.
  - Total delay: rsp_valid is high exactly READ_LATENCY cycles after the request cycle.
- Producing a response (registered on the edge):
  - Aligned and in range: rsp_data = store[word index], rsp_error=0.
  - Misaligned (req_address[1:0]!=0) or word index (req_address>>2) >= DEPTH: rsp_data=0, rsp_error=1.
  - The error path uses the same latency as a normal read.
  - rsp_valid pulses for one cycle; rsp_data and rsp_error hold afterwards.
- Back-to-back requests:
  - The cycle in which rsp_valid=1 is IDLE, so a new request is accepted in that cycle.
  - With READ_LATENCY=1, a request every cycle gives a response every cycle.
- req_valid=1 while busy: the request is ignored, req_dropped pulses on the next cycle, and the in-flight request is unaffected.
- Load port:
  - Always serviced, independent of state.
  - Aligned, in-range writes take effect at the edge.
  - Misaligned or out-of-range loads are silently ignored.
- Load vs read collision:
  - Rule: a load to the same word on the same edge that produces a response returns the OLD data (read-before-write).
  - A load on any earlier edge is visible in the response.
- Width rules:
  - Word index is req_address[ADDR_WIDTH-1:2].
  - The DEPTH comparison is unsigned and done at full index width; there is no wrap-around of out-of-range addresses.

Decomposition:
- Shared package:
  - State encoding (IDLE, WAIT).
  - Counter width constant: 4 bits, derived from the READ_LATENCY max of 15.
  - Alignment mask constant: 2'b00.
  - Word-index helper function.
- Sub-module fetch_store_array:
  - DEPTH×DATA_WIDTH storage with one synchronous write port and one read port.
  - Read is registered under an enable, with read-before-write semantics.
  - The controller FSM, counter and range checks stay in the top level.

Test Plan:
- Load 0x00000004 := 0xDEADBEEF. Request 0x4 with READ_LATENCY=1 → next cycle rsp_valid=1, rsp_data=0xDEADBEEF, rsp_error=0; busy never asserts.
- READ_LATENCY=3. Request 0x8 (loaded 0x12345678) at cycle N → busy=1 in N+1..N+2; rsp_valid only at N+3 with 0x12345678. A second req_valid at N+1 → req_dropped=1 at N+2 and the first response is unchanged.
- Request 0x6 → rsp_error=1, rsp_data=0. Request 4*DEPTH (0x1000) → rsp_error=1. Both use normal latency.
- READ_LATENCY=1, requests at 0x0, 0x4, 0x8 on consecutive cycles → three consecutive rsp_valid pulses with the loaded words in order.
- On the edge that produces a response for 0x10 (old 0x1), load 0x10 := 0x2 → rsp_data=0x1; a following request to 0x10 returns 0x2.
- READ_LATENCY=3. Assert reset low mid-WAIT, release → all outputs 0, busy=0, and no rsp_valid pulse ever arrives for the aborted request.

Source files
------------

// File: rtl/instruction_fetch_responder_pkg.sv
// instruction_fetch_responder_pkg: shared state encoding, counter width and address helpers
package instruction_fetch_responder_pkg;
  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_WAIT = 1'b1;
  localparam int CNT_WIDTH = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b00;
  function automatic logic [63:0] wordIndex(input logic [63:0] addr);
    return addr >> 2;
  endfunction
endpackage

// File: rtl/fetch_store_array.sv
// fetch_store_array: word store with one write port and a registered, read-before-write read port
module fetch_store_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wrEn,
  input  logic [IDX_W-1:0]      wrIdx,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  rdEn,
  input  logic [IDX_W-1:0]      rdIdx,
  output logic [DATA_WIDTH-1:0] rdData
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (wrEn) mem[wrIdx] <= wrData;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdData <= '0;
    else if (rdEn) rdData <= mem[rdIdx];
endmodule

// File: rtl/instruction_fetch_responder.sv
// instruction_fetch_responder: fixed-latency instruction fetch responder with internal store
module instruction_fetch_responder
  import instruction_fetch_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_address,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  req_dropped,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_address,
  input  logic [DATA_WIDTH-1:0] load_data
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [0:0] state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] capAddr, rdAddr;
  logic [63:0] rdIndex, loadIndex;
  logic accept, produce, rdOk, loadOk;
  logic [DATA_WIDTH-1:0] storeData;
  always_comb begin
    accept = state == STATE_IDLE && req_valid;
    rdAddr = state == STATE_WAIT ? capAddr : req_address;
    produce = (accept && READ_LATENCY == 1) || (state == STATE_WAIT && cnt == CNT_WIDTH'(1));
    rdIndex = wordIndex(64'(rdAddr));
    rdOk = rdAddr[1:0] == ALIGN_MASK && rdIndex < 64'(DEPTH);
    loadIndex = wordIndex(64'(load_address));
    loadOk = load_en && load_address[1:0] == ALIGN_MASK && loadIndex < 64'(DEPTH);
  end
  fetch_store_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) store (
    .clk(clk),
    .reset(reset),
    .wrEn(loadOk),
    .wrIdx(IDX_W'(loadIndex)),
    .wrData(load_data),
    .rdEn(produce && rdOk),
    .rdIdx(IDX_W'(rdIndex)),
    .rdData(storeData)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= STATE_IDLE;
      cnt <= '0;
      capAddr <= '0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      req_dropped <= 1'b0;
    end else begin
      rsp_valid <= produce;
      req_dropped <= state == STATE_WAIT && req_valid;
      if (produce) rsp_error <= !rdOk;
      if (accept) begin
        capAddr <= req_address;
        cnt <= CNT_WIDTH'(READ_LATENCY - 1);
        state <= READ_LATENCY == 1 ? STATE_IDLE : STATE_WAIT;
      end else if (state == STATE_WAIT) begin
        cnt <= cnt - CNT_WIDTH'(1);
        if (cnt == CNT_WIDTH'(1)) state <= STATE_IDLE;
      end
    end
  // Error responses carry zero data; the store's read register is only refreshed on good reads.
  assign rsp_data = rsp_error ? '0 : storeData;
  assign busy = state == STATE_WAIT;
endmodule
